// File: rtl/fetch_sequencer.sv
// Multi-cycle control sequencer for the 10-bit CPU: fetch, decode, execute,
// memory access and write-back, with a bounded wait on each memory handshake.
module fetch_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             imem_ack,
  input  logic [9:0]       imem_data,
  input  logic             dmem_ack,
  input  logic             zero,
  output logic             imem_req,
  output logic             dmem_re,
  output logic             dmem_we,
  output logic [9:0]       ir,
  output logic             pc_en,
  output logic             pc_ctrl,
  output logic             alu_en,
  output logic             rf_we,
  output logic             retire,
  output logic             illegal,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] insn_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_FAULT
  } state_t;

  // The wait counter counts missed-ack cycles; the last allowed miss is TIMEOUT-1.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_cnt;
  logic       wait_expired;

  logic [3:0] opcode;
  logic       is_alu;
  logic       is_ld;
  logic       is_st;
  logic       is_mem;
  logic       is_br;
  logic       is_bz;
  logic       is_halt;
  logic       is_ill;

  assign opcode       = ir[9:6];
  assign is_alu       = ~opcode[3];
  assign is_ld        = (opcode == 4'b1000);
  assign is_st        = (opcode == 4'b1001);
  assign is_mem       = is_ld | is_st;
  assign is_br        = (opcode == 4'b1010);
  assign is_bz        = (opcode == 4'b1011);
  assign is_halt      = (opcode == 4'b1111);
  assign is_ill       = (opcode == 4'b1101) || (opcode == 4'b1110);
  assign wait_expired = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack)          state_next = S_DECODE;
        else if (wait_expired) state_next = S_FAULT;
      end
      S_DECODE: begin
        if (is_alu)       state_next = S_EXEC;
        else if (is_mem)  state_next = S_MEM;
        else if (is_halt) state_next = S_HALT;
        else              state_next = S_FETCH;
      end
      S_EXEC: state_next = S_WB;
      S_MEM: begin
        if (dmem_ack)          state_next = is_ld ? S_WB : S_FETCH;
        else if (wait_expired) state_next = S_FAULT;
      end
      S_WB: state_next = S_FETCH;
      S_HALT: begin
        if (start) state_next = S_FETCH;
      end
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_IDLE;
    endcase
  end

  // pc_en and retire always rise together: the PC only moves when an instruction completes.
  always_comb begin
    imem_req = 1'b0;
    dmem_re  = 1'b0;
    dmem_we  = 1'b0;
    pc_en    = 1'b0;
    pc_ctrl  = 1'b0;
    alu_en   = 1'b0;
    rf_we    = 1'b0;
    retire   = 1'b0;
    illegal  = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    case (state)
      S_FETCH: imem_req = 1'b1;
      S_DECODE: begin
        if (!is_alu && !is_mem) begin
          pc_en   = 1'b1;
          retire  = 1'b1;
          pc_ctrl = is_br | (is_bz & zero);
          illegal = is_ill;
        end
      end
      S_EXEC: alu_en = 1'b1;
      S_MEM: begin
        dmem_re = is_ld;
        dmem_we = is_st;
        if (dmem_ack && is_st) begin
          pc_en  = 1'b1;
          retire = 1'b1;
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        pc_en  = 1'b1;
        retire = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

  // Instruction register, handshake wait counter and saturating retire counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir         <= '0;
      wait_cnt   <= '0;
      insn_count <= '0;
    end else begin
      if (state == S_FETCH && imem_ack) begin
        ir <= imem_data;
      end
      if ((state == S_FETCH && !imem_ack) || (state == S_MEM && !dmem_ack)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= '0;
      end
      if (retire && (insn_count != {CNT_W{1'b1}})) begin
        insn_count <= insn_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a random
// instruction stream checked against a per-instruction-class timing model.
module tb_fetch_sequencer;

  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             imem_ack;
  logic [9:0]       imem_data;
  logic             dmem_ack;
  logic             zero;
  logic             imem_req;
  logic             dmem_re;
  logic             dmem_we;
  logic [9:0]       ir;
  logic             pc_en;
  logic             pc_ctrl;
  logic             alu_en;
  logic             rf_we;
  logic             retire;
  logic             illegal;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] insn_count;

  int compared   = 0;
  int mismatched = 0;
  int exp_count  = 0;

  localparam logic [10:0] C_NONE  = 11'd0;
  localparam logic [10:0] C_IREQ  = 11'b100_0000_0000;
  localparam logic [10:0] C_DRE   = 11'b010_0000_0000;
  localparam logic [10:0] C_DWE   = 11'b001_0000_0000;
  localparam logic [10:0] C_PCEN  = 11'b000_1000_0000;
  localparam logic [10:0] C_PCCTL = 11'b000_0100_0000;
  localparam logic [10:0] C_ALU   = 11'b000_0010_0000;
  localparam logic [10:0] C_RFWE  = 11'b000_0001_0000;
  localparam logic [10:0] C_RET   = 11'b000_0000_1000;
  localparam logic [10:0] C_ILL   = 11'b000_0000_0100;
  localparam logic [10:0] C_HALT  = 11'b000_0000_0010;
  localparam logic [10:0] C_FAULT = 11'b000_0000_0001;
  localparam logic [10:0] C_DONE  = C_PCEN | C_RET;

  logic [10:0] obs;
  assign obs = {imem_req, dmem_re, dmem_we, pc_en, pc_ctrl, alu_en, rf_we,
                retire, illegal, halted, fault};

  fetch_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .imem_ack(imem_ack),
    .imem_data(imem_data), .dmem_ack(dmem_ack), .zero(zero),
    .imem_req(imem_req), .dmem_re(dmem_re), .dmem_we(dmem_we), .ir(ir),
    .pc_en(pc_en), .pc_ctrl(pc_ctrl), .alu_en(alu_en), .rf_we(rf_we),
    .retire(retire), .illegal(illegal), .halted(halted), .fault(fault),
    .insn_count(insn_count)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic st, input logic ia, input logic [9:0] id,
                               input logic da, input logic z);
    start     = st;
    imem_ack  = ia;
    imem_data = id;
    dmem_ack  = da;
    zero      = z;
  endtask

  task automatic checkOutput(input string tag, input logic [10:0] exp);
    #1;
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s controls observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkValue(input string tag, input logic [15:0] got, input logic [15:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic noise(input logic z);
    applyStimulus(1'($urandom), 1'($urandom), 10'($urandom), 1'($urandom), z);
  endtask

  task automatic countRetire();
    if (exp_count < CNT_MAX) exp_count++;
  endtask

  // Runs one instruction starting in FETCH; ends in FETCH, or in HALT for a HALT word.
  task automatic runInsn(input logic [9:0] word, input int idelay, input int ddelay,
                         input logic zval);
    logic [3:0]  opc;
    logic [10:0] dec;
    opc = word[9:6];
    for (int i = 0; i < idelay; i++) begin
      applyStimulus(1'($urandom), 1'b0, 10'($urandom), 1'($urandom), 1'($urandom));
      checkOutput("fetch_wait", C_IREQ);
      tick();
    end
    applyStimulus(1'($urandom), 1'b1, word, 1'($urandom), 1'($urandom));
    checkOutput("fetch_ack", C_IREQ);
    tick();
    noise(zval);
    if (!opc[3] || opc == 4'b1000 || opc == 4'b1001) dec = C_NONE;
    else if (opc == 4'b1010) dec = C_DONE | C_PCCTL;
    else if (opc == 4'b1011) dec = C_DONE | (zval ? C_PCCTL : C_NONE);
    else if (opc == 4'b1101 || opc == 4'b1110) dec = C_DONE | C_ILL;
    else dec = C_DONE;
    checkOutput("decode", dec);
    checkValue("ir", 16'(ir), 16'(word));
    tick();
    if (!opc[3]) begin
      noise(1'($urandom));
      checkOutput("exec", C_ALU);
      tick();
      noise(1'($urandom));
      checkOutput("wb", C_RFWE | C_DONE);
      tick();
    end else if (opc == 4'b1000 || opc == 4'b1001) begin
      for (int i = 0; i < ddelay; i++) begin
        applyStimulus(1'($urandom), 1'($urandom), 10'($urandom), 1'b0, 1'($urandom));
        checkOutput("mem_wait", (opc == 4'b1000) ? C_DRE : C_DWE);
        tick();
      end
      applyStimulus(1'($urandom), 1'($urandom), 10'($urandom), 1'b1, 1'($urandom));
      checkOutput("mem_ack", (opc == 4'b1000) ? C_DRE : (C_DWE | C_DONE));
      tick();
      if (opc == 4'b1000) begin
        noise(1'($urandom));
        checkOutput("ld_wb", C_RFWE | C_DONE);
        tick();
      end
    end
    countRetire();
    checkValue("insn_count", 16'(insn_count), 16'(exp_count));
  endtask

  task automatic leaveHalt();
    applyStimulus(1'b0, 1'($urandom), 10'($urandom), 1'($urandom), 1'($urandom));
    checkOutput("halted", C_HALT);
    tick();
    applyStimulus(1'b1, 1'($urandom), 10'($urandom), 1'($urandom), 1'($urandom));
    checkOutput("halted_start", C_HALT);
    tick();
  endtask

  initial begin
    logic [3:0] opc;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    checkOutput("reset_outputs", C_NONE);
    checkValue("reset_ir", 16'(ir), 16'd0);
    checkValue("reset_count", 16'(insn_count), 16'd0);
    tick();
    reset = 1'b1;

    applyStimulus(1'b0, 1'b1, 10'h3ff, 1'b1, 1'b0);
    checkOutput("idle", C_NONE);
    tick();
    applyStimulus(1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    checkOutput("idle_start", C_NONE);
    tick();

    runInsn(10'b0000_000001, 0, 0, 1'b0);
    runInsn(10'b1011_000000, 1, 0, 1'b1);
    runInsn(10'b1011_000000, 0, 0, 1'b0);
    runInsn(10'b1000_000101, 0, 3, 1'b0);
    runInsn(10'b1001_000110, 2, 2, 1'b0);
    runInsn(10'b1010_010101, TIMEOUT - 1, 0, 1'b0);
    runInsn(10'b1000_000001, 0, TIMEOUT - 1, 1'b0);
    runInsn(10'b1101_000000, 0, 0, 1'b0);
    runInsn(10'b1110_111111, 0, 0, 1'b1);
    runInsn(10'b1100_000000, 0, 0, 1'b1);
    runInsn(10'b1111_000000, 0, 0, 1'b0);
    leaveHalt();

    for (int n = 0; n < 40; n++) begin
      opc = 4'($urandom);
      runInsn({opc, 6'($urandom)}, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              1'($urandom));
      if (opc == 4'b1111) leaveHalt();
    end

    // Reset while a store request is outstanding.
    applyStimulus(1'b0, 1'b1, 10'b1001_000000, 1'b0, 1'b0);
    checkOutput("st_fetch", C_IREQ);
    tick();
    noise(1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    checkOutput("st_mem", C_DWE);
    #2 reset = 1'b0;
    exp_count = 0;
    checkOutput("reset_mid_mem", C_NONE);
    checkValue("reset_mid_ir", 16'(ir), 16'd0);
    checkValue("reset_mid_count", 16'(insn_count), 16'(exp_count));
    tick();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 10'd0, 1'b1, 1'b0);
    checkOutput("idle_after_reset", C_NONE);
    tick();
    applyStimulus(1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    checkOutput("idle_start2", C_NONE);
    tick();
    runInsn(10'b0011_000000, 0, 0, 1'b0);

    // Fetch timeout into FAULT, which ignores start and acks.
    for (int i = 0; i < TIMEOUT; i++) begin
      applyStimulus(1'($urandom), 1'b0, 10'($urandom), 1'($urandom), 1'b0);
      checkOutput("fetch_timeout_wait", C_IREQ);
      tick();
    end
    applyStimulus(1'b1, 1'b1, 10'd0, 1'b1, 1'b0);
    checkOutput("fault_start", C_FAULT);
    tick();
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    checkOutput("fault_sticky", C_FAULT);
    #2 reset = 1'b0;
    exp_count = 0;
    checkOutput("fault_reset", C_NONE);
    tick();
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    checkOutput("idle_after_fault", C_NONE);
    tick();

    // Data-memory timeout on a load also ends in FAULT.
    applyStimulus(1'b0, 1'b1, 10'b1000_000000, 1'b0, 1'b0);
    checkOutput("ld_fetch", C_IREQ);
    tick();
    noise(1'b0);
    tick();
    for (int i = 0; i < TIMEOUT; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), 10'($urandom), 1'b0, 1'b0);
      checkOutput("mem_timeout_wait", C_DRE);
      tick();
    end
    noise(1'b0);
    checkOutput("mem_fault", C_FAULT);
    checkValue("fault_count", 16'(insn_count), 16'(exp_count));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
